// File: rtl/mant_sub_seq.sv
// rtl/mant_sub_seq.sv - byte-serial mantissa magnitude subtractor |A - B|
module mant_sub_seq #(
    parameter int WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_sign,
    output logic             o_zero
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic [IDX_W-1:0] idx;
    logic             carry;

    logic [7:0]       slice_x;
    logic [7:0]       slice_y;
    logic [8:0]       slice_out;
    logic [WIDTH-1:0] res_next;
    logic             last_byte;

    // 8-bit carry-lookahead add: every carry is formed directly from g/p terms
    function automatic logic [8:0] cla8(input logic [7:0] x, input logic [7:0] y,
                                        input logic cin);
        logic [7:0] g;
        logic [7:0] p;
        logic [8:0] c;
        logic       pp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin);
        end
        return {c[8], p ^ c[7:0]};
    endfunction

    // Slice operands: SUB adds a + ~b, NEG adds ~res + 0 (carry supplies the +1)
    always_comb begin
        slice_x = a_r[{idx, 3'b000} +: 8];
        slice_y = ~b_r[{idx, 3'b000} +: 8];
        if (state == NEG) begin
            slice_x = ~res_r[{idx, 3'b000} +: 8];
            slice_y = 8'h00;
        end
        slice_out = cla8(slice_x, slice_y, carry);
        last_byte = (idx == LAST_IDX);
    end

    // Result with the current slice merged in, so DONE outputs see the final byte
    always_comb begin
        res_next = res_r;
        res_next[{idx, 3'b000} +: 8] = slice_out[7:0];
    end

    // Control FSM with registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_diff  <= '0;
            o_sign  <= 1'b0;
            o_zero  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        a_r    <= i_data_a;
                        b_r    <= i_data_b;
                        idx    <= '0;
                        carry  <= 1'b1;
                        o_busy <= 1'b1;
                        state  <= SUB;
                    end
                end
                SUB: begin
                    res_r <= res_next;
                    carry <= slice_out[8];
                    idx   <= idx + 1'b1;
                    if (last_byte) begin
                        if (slice_out[8]) begin
                            o_sign  <= 1'b0;
                            o_diff  <= res_next;
                            o_zero  <= (res_next == '0);
                            o_valid <= 1'b1;
                            state   <= DONE;
                        end else begin
                            o_sign <= 1'b1;
                            idx    <= '0;
                            carry  <= 1'b1;
                            state  <= NEG;
                        end
                    end
                end
                NEG: begin
                    res_r <= res_next;
                    carry <= slice_out[8];
                    idx   <= idx + 1'b1;
                    if (last_byte) begin
                        o_diff  <= res_next;
                        o_zero  <= (res_next == '0);
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    idx    <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mant_sub_seq.sv
// tb/tb_mant_sub_seq.sv - scoreboard bench for mant_sub_seq
module tb_mant_sub_seq;

    localparam int WIDTH  = 24;
    localparam int NBYTES = WIDTH / 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             sign;
        logic             zero;
        int               lat;
        int               start_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] data_a = '0;
    logic [WIDTH-1:0] data_b = '0;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] diff;
    logic             sign;
    logic             zero;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_busy_next = 0;
    exp_t sb[$];

    mant_sub_seq #(.WIDTH(WIDTH)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_data_a (data_a),
        .i_data_b (data_b),
        .o_busy   (busy),
        .o_valid  (valid),
        .o_diff   (diff),
        .o_sign   (sign),
        .o_zero   (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive a start request this cycle; optionally record the expected result
    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit push);
        exp_t e;
        start  = 1'b1;
        data_a = a;
        data_b = b;
        if (push) begin
            e.sign      = (a < b);
            e.diff      = (a >= b) ? a - b : b - a;
            e.zero      = (a == b);
            e.lat       = (a >= b) ? NBYTES + 1 : 2 * NBYTES + 1;
            e.start_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        drive(a, b, 1'b1);
        tick();
        start  = 1'b0;
        data_a = $urandom;
        data_b = $urandom;
        wait_done();
        tick();
    endtask

    // Output monitor: compare every o_valid against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (chk_busy_next) check("busy_after_valid", 32'(busy), 32'd0);
        chk_busy_next = 0;
        if (valid) begin
            chk_busy_next = 1;
            check("busy_at_valid", 32'(busy), 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("diff", 32'(diff), 32'(e.diff));
                check("sign", 32'(sign), 32'(e.sign));
                check("zero", 32'(zero), 32'(e.zero));
                check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        exp_t dropped;

        tick();
        tick();
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_diff",  32'(diff),  32'd0);
        check("rst_sign",  32'(sign),  32'd0);
        check("rst_zero",  32'(zero),  32'd0);
        rst_n = 1'b1;

        run_op(24'h800000, 24'h000001);
        run_op(24'h000001, 24'h800000);
        run_op(24'h010000, 24'h0000FF);
        run_op(24'h000000, 24'hFFFFFF);
        run_op(24'h123456, 24'h123456);
        run_op(24'hFFFFFF, 24'h000000);

        // start pulses in cycles 2 and 4 are ignored; cycle 5 is accepted
        drive(24'h800000, 24'h000001, 1'b1);
        tick();
        start = 1'b0;
        check("busy_cycle1", 32'(busy), 32'd1);
        tick();
        drive(24'h000005, 24'h000009, 1'b0);
        tick();
        start = 1'b0;
        tick();
        drive(24'h000007, 24'h000003, 1'b0);
        tick();
        drive(24'h00ABCD, 24'h00ABCE, 1'b1);
        tick();
        start = 1'b0;
        wait_done();
        tick();

        // reset in cycle 5 of an A<B op aborts it
        run_op(24'h000010, 24'h000001);
        drive(24'h000001, 24'h800000, 1'b1);
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy",  32'(busy),  32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_diff",  32'(diff),  32'd0);
        check("midrst_sign",  32'(sign),  32'd0);
        check("midrst_zero",  32'(zero),  32'd0);
        if (sb.size() != 0) dropped = sb.pop_back();
        tick();
        tick();
        rst_n = 1'b1;
        run_op(24'h000001, 24'h800000);

        for (int i = 0; i < 10; i++) begin
            ra = WIDTH'($urandom);
            rb = (i % 4 == 3) ? ra : WIDTH'($urandom);
            run_op(ra, rb);
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
